// File: rtl/neuron_mac_multilane_pkg.sv
// neuron_pkg: FSM/activation types and arithmetic helpers shared by neuron_mac_multilane
package neuron_pkg;
  typedef enum logic [2:0] {IDLE, ACC, BIAS, ACT, HOLD} state_e;
  typedef enum logic {LINEAR, RELU} act_e;
  function automatic int beats(input int num_weight, input int lanes);
    return num_weight / lanes;
  endfunction
  function automatic logic signed [64:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [64:0] s, mx, mn;
    s = 65'(a) + 65'(b);
    mx = (65'sd1 <<< (w - 1)) - 65'sd1;
    mn = -(65'sd1 <<< (w - 1));
    return s > mx ? mx : s < mn ? mn : s;
  endfunction
endpackage

// File: rtl/neuron_mac_multilane_if.sv
// neuron_mac_multilane_if: input stream, config bus and result handshake of one neuron
// master = upstream/config driver, slave = neuron_mac_multilane
interface neuron_mac_multilane_if #(parameter int DW = 16, parameter int LANES = 2);
  logic [LANES*DW-1:0] in_data;
  logic in_valid, in_ready;
  logic weight_valid, bias_valid;
  logic [31:0] weight_value, bias_value, config_layer_num, config_neuron_num;
  logic act_sel;
  logic [DW-1:0] out;
  logic out_valid, out_ready, busy;
  modport master(output in_data, in_valid, weight_valid, weight_value, bias_valid, bias_value,
                 config_layer_num, config_neuron_num, act_sel, out_ready,
                 input in_ready, out, out_valid, busy);
  modport slave(input in_data, in_valid, weight_valid, weight_value, bias_valid, bias_value,
                config_layer_num, config_neuron_num, act_sel, out_ready,
                output in_ready, out, out_valid, busy);
endinterface

// File: rtl/neuron_mac_multilane_wmem.sv
// neuron_wmem: LANES-wide weight RAM, one lane-enabled write port, registered read port
// ports: clk, we/lane_en/waddr/wdata write, raddr in, rdata out (one cycle after raddr)
module neuron_wmem #(
  parameter int DW = 16,
  parameter int LANES = 2,
  parameter int ROWS = 5,
  parameter int RW = 3
) (
  input  logic clk,
  input  logic we,
  input  logic [LANES-1:0] lane_en,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr,
  output logic [LANES-1:0][DW-1:0] rdata
);
  logic [LANES-1:0][DW-1:0] mem [ROWS];
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (we && lane_en[l]) mem[waddr][l] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/neuron_mac_multilane.sv
// neuron_mac_multilane: LANES-wide MAC neuron with bias, linear/ReLU activation and ready/valid output
// ports: clk, rst_n (async active-low), bus (neuron_mac_multilane_if.slave); NEURON_SAT_EN selects saturating adds
module neuron_mac_multilane
  import neuron_pkg::*;
#(
  parameter int LAYER_NO = 4,
  parameter int NEURON_NO = 2,
  parameter int NUM_WEIGHT = 10,
  parameter int DATA_WIDTH = 16,
  parameter int LANES = 2,
  parameter int WEIGHT_INT_WIDTH = 1
) (
  input logic clk,
  input logic rst_n,
  neuron_mac_multilane_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int F = DW - WEIGHT_INT_WIDTH;
  localparam int AW = 2 * DW;
  localparam int TW = AW + $clog2(LANES);
  localparam int ROWS = beats(NUM_WEIGHT, LANES);
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam logic signed [AW-1:0] OMAX = AW'({1'b0, {(DW-1){1'b1}}});
  localparam logic signed [AW-1:0] OMIN = ~OMAX;
  state_e state, state_n;
  act_e act_r;
  logic [RW-1:0] wrow, beat;
  logic [LW-1:0] wlane;
  logic [LANES-1:0][DW-1:0] in_reg, w_rd;
  logic signed [AW-1:0] prod [LANES];
  logic signed [TW-1:0] tree;
  logic signed [AW-1:0] acc, acc_nxt, biased, bias_sum, bias_ext, shifted;
  logic signed [DW-1:0] bias_r, clamped;
  logic cfg_hit, w_we, b_we, accept, last_beat, last_taken, v1, l1, v2, l2, unused_hi;
  assign unused_hi = ^{bus.weight_value[31:DW], bus.bias_value[31:DW]};
  assign cfg_hit = state == IDLE && bus.config_layer_num == 32'(LAYER_NO) && bus.config_neuron_num == 32'(NEURON_NO);
  assign w_we = cfg_hit && bus.weight_valid;
  assign b_we = cfg_hit && bus.bias_valid;
  assign bus.in_ready = state == IDLE || (state == ACC && !last_taken);
  assign bus.busy = state != IDLE;
  assign bus.out_valid = state == HOLD;
  assign accept = bus.in_valid && bus.in_ready;
  assign last_beat = beat == RW'(ROWS - 1);
  neuron_wmem #(.DW(DW), .LANES(LANES), .ROWS(ROWS), .RW(RW)) u_wmem (
    .clk(clk),
    .we(w_we),
    .lane_en(LANES'(1) << wlane),
    .waddr(wrow),
    .wdata(bus.weight_value[DW-1:0]),
    .raddr(beat),
    .rdata(w_rd)
  );
  always_comb begin
    tree = '0;
    for (int l = 0; l < LANES; l++) tree = tree + TW'(prod[l]);
  end
  assign bias_ext = AW'(bias_r) <<< F;
  assign shifted = biased >>> F;
  assign clamped = shifted > OMAX ? DW'(OMAX) : shifted < OMIN ? DW'(OMIN) : DW'(shifted);
`ifdef NEURON_SAT_EN
  assign acc_nxt = AW'(sat_add(64'(acc), 64'(tree), AW));
  assign bias_sum = AW'(sat_add(64'(acc), 64'(bias_ext), AW));
`else
  assign acc_nxt = acc + AW'(tree);
  assign bias_sum = acc + bias_ext;
`endif
  always_comb
    state_n = state == IDLE ? (accept ? ACC : IDLE)
            : state == ACC  ? (l2 ? BIAS : ACC)
            : state == BIAS ? ACT
            : state == ACT  ? HOLD
            : (bus.out_ready ? IDLE : HOLD);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (accept) in_reg <= bus.in_data;
    for (int l = 0; l < LANES; l++) prod[l] <= AW'($signed(in_reg[l])) * AW'($signed(w_rd[l]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrow <= '0;
      wlane <= '0;
      bias_r <= '0;
      beat <= '0;
      last_taken <= 1'b0;
      {v1, l1, v2, l2} <= '0;
      acc <= '0;
      biased <= '0;
      act_r <= LINEAR;
      bus.out <= '0;
    end else begin
      if (w_we) begin
        wlane <= wlane == LW'(LANES - 1) ? '0 : wlane + LW'(1);
        if (wlane == LW'(LANES - 1)) wrow <= wrow == RW'(ROWS - 1) ? '0 : wrow + RW'(1);
      end
      if (b_we) bias_r <= bus.bias_value[DW-1:0];
      if (accept) beat <= last_beat ? '0 : beat + RW'(1);
      last_taken <= state_n == IDLE ? 1'b0 : (accept && last_beat) ? 1'b1 : last_taken;
      v1 <= accept;
      l1 <= accept && last_beat;
      v2 <= v1;
      l2 <= l1;
      acc <= (state == HOLD && bus.out_ready) ? '0 : v2 ? acc_nxt : acc;
      if (state == BIAS) begin
        biased <= bias_sum;
        act_r <= act_e'(bus.act_sel);
      end
      if (state == ACT) bus.out <= (act_r == RELU && clamped[DW-1]) ? '0 : clamped;
    end
  end
endmodule

// File: tb/tb_neuron_mac_multilane.sv
// tb_neuron_mac_multilane: directed self-checking bench for neuron_mac_multilane (DW=16, LANES=2, NUM_WEIGHT=4)
module tb_neuron_mac_multilane;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
`ifdef NEURON_SAT_EN
  localparam logic [15:0] OVF = 16'h7FFF;
`else
  localparam logic [15:0] OVF = 16'h0000;
`endif
  always #5 clk = ~clk;
  neuron_mac_multilane_if #(.DW(16), .LANES(2)) bus ();
  neuron_mac_multilane #(
    .LAYER_NO(4), .NEURON_NO(2), .NUM_WEIGHT(4), .DATA_WIDTH(16), .LANES(2), .WEIGHT_INT_WIDTH(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr_w(input logic [15:0] v, input logic [31:0] nid);
    @(negedge clk);
    bus.config_neuron_num = nid;
    bus.weight_value = {16'h0, v};
    bus.weight_valid = 1;
    @(negedge clk);
    bus.weight_valid = 0;
    bus.config_neuron_num = 2;
  endtask
  task automatic wr_b(input logic [15:0] v);
    @(negedge clk);
    bus.bias_value = {16'h0, v};
    bus.bias_valid = 1;
    @(negedge clk);
    bus.bias_valid = 0;
  endtask
  task automatic load4(input logic [15:0] w, input logic [15:0] b);
    repeat (4) wr_w(w, 2);
    wr_b(b);
  endtask
  task automatic run(input string tag, input logic [15:0] x, input logic act, input logic [15:0] exp);
    int n = 0;
    bus.act_sel = act;
    @(negedge clk);
    bus.in_data = {x, x};
    bus.in_valid = 1;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 0;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_out"}, 32'(bus.out), 32'(exp));
  endtask
  initial begin
    bus.in_data = '0;
    bus.in_valid = 0;
    bus.weight_valid = 0;
    bus.weight_value = '0;
    bus.bias_valid = 0;
    bus.bias_value = '0;
    bus.config_layer_num = 4;
    bus.config_neuron_num = 2;
    bus.act_sel = 0;
    bus.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'(bus.out), 0);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_rdy", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1;
    load4(16'h2000, 16'h2000);
    run("lin", 16'h4000, 0, 16'h6000);
    @(negedge clk);
    chk("lin_idle_rdy", 32'(bus.in_ready), 1);
    load4(16'hE000, 16'h0000);
    run("neg", 16'h4000, 0, 16'hC000);
    @(negedge clk);
    run("relu", 16'h4000, 1, 16'h0000);
    @(negedge clk);
    bus.out_ready = 0;
    run("bp", 16'h4000, 0, 16'hC000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out", 32'(bus.out), 32'hC000);
      chk("bp_rdy", 32'(bus.in_ready), 0);
      bus.weight_value = 32'h2000;
      bus.bias_value = 32'h7FFF;
      bus.weight_valid = i == 2;
      bus.bias_valid = i == 2;
    end
    bus.weight_valid = 0;
    bus.bias_valid = 0;
    bus.out_ready = 1;
    @(negedge clk);
    chk("bp_rel_rdy", 32'(bus.in_ready), 1);
    chk("bp_rel_ov", 32'(bus.out_valid), 0);
    run("bp_after", 16'h4000, 0, 16'hC000);
    @(negedge clk);
    repeat (4) wr_w(16'h2000, 3);
    run("mis", 16'h4000, 0, 16'hC000);
    @(negedge clk);
    repeat (4) wr_w(16'h2000, 2);
    wr_w(16'h4000, 2);
    run("wrap", 16'h4000, 0, 16'h5000);
    @(negedge clk);
    repeat (4) wr_w(16'h8000, 2);
    run("ovf", 16'h8000, 0, OVF);
    @(negedge clk);
    @(negedge clk);
    bus.in_data = {16'h4000, 16'h4000};
    bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_ov", 32'(bus.out_valid), 0);
    chk("mid_rdy", 32'(bus.in_ready), 1);
    chk("mid_acc", 32'(dut.acc), 0);
    @(negedge clk);
    rst_n = 1;
    run("retain", 16'h4000, 0, 16'h8000);
    @(negedge clk);
    load4(16'h2000, 16'h2000);
    run("fresh", 16'h4000, 0, 16'h6000);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neuron_mac_multilane.md
# neuron_mac_multilane

Parametrised multi-lane fully-connected neuron for the FNN accelerator datapath. Each accepted beat carries `LANES` inputs; the block multiplies them against locally stored weights, accumulates the full weighted sum with optional saturation, adds a runtime-loaded bias, and applies a runtime-selected linear or ReLU activation. It sits in a layer array where every instance shares the weight/bias configuration bus and the input stream. Instances are selected by layer/neuron ID. Unlike the single-lane neuron, it has a ready/valid output handshake, so it tolerates downstream backpressure.

## Interface
- `LAYER_NO`, 4, layer ID matched against `config_layer_num`
- `NEURON_NO`, 2, neuron ID matched against `config_neuron_num`
- `NUM_WEIGHT`, 10, weights per neuron; must be a multiple of `LANES`
- `DATA_WIDTH`, 16, signed input, weight, bias and output width (DW)
- `LANES`, 2, inputs consumed per beat; 1..8
- `WEIGHT_INT_WIDTH`, 1, integer bits of the fixed-point format; fraction F = DW − WEIGHT_INT_WIDTH
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `in_data`  in  LANES*DW  lane i in bits [i*DW +: DW]
- `in_valid` / `in_ready`  in / out  1  input beat handshake
- `weight_valid`, `weight_value`  in  1, 32  weight write; low DW bits are used
- `bias_valid`, `bias_value`  in  1, 32  bias write; low DW bits are used
- `config_layer_num`, `config_neuron_num`  in  32, 32  write target select
- `act_sel`  in  1  0 = linear, 1 = ReLU; sampled when the activation state is entered
- `out` / `out_valid` / `out_ready`  out / out / in  DW, 1, 1  result handshake
- `busy`  out  1  high in every state except IDLE

## Operation
- A write is selected when its valid signal is high and both config IDs match the parameters. Writes are accepted only in IDLE; selected writes in any other state are dropped.
- Weight write k goes to lane k mod LANES, row k div LANES. The write counter wraps from NUM_WEIGHT−1 back to 0. A bias write overwrites the bias register.
- FSM states and transitions:
  - IDLE → ACC on the first accepted beat.
  - ACC: accepts beats 0..BEATS−1, where BEATS = NUM_WEIGHT/LANES. Moves to BIAS when the last product has been accumulated.
  - BIAS → ACT after 1 cycle.
  - ACT → HOLD after 1 cycle.
  - HOLD: waits for `out_valid && out_ready`, then returns to IDLE.
- `in_ready` is high in IDLE and in ACC until the last beat is accepted, and low otherwise. Gaps in `in_valid` during ACC are legal.
- Arithmetic:
  - Each product is DW×DW signed giving 2DW bits.
  - The lane adder tree is 2DW + clog2(LANES) bits.
  - The accumulator is 2DW bits.
  - The bias is sign-extended and shifted left by F.
  - Result = acc >>> F, clamped to the signed DW range.
  - ReLU forces any negative result to 0.

## Timing
- Reset values: `out` = 0, `out_valid` = 0, `in_ready` = 1, `busy` = 0; accumulator, write counter and bias register = 0. Weight RAM contents are not reset.
- Pipeline, with the last beat accepted in cycle T:
  - T+1: weight read and input register
  - T+2: product register
  - T+3: accumulate
  - T+4: bias add
  - T+5: `out_valid` = 1
- `out` and `out_valid` are held stable until the handshake. `in_ready` rises the cycle after the handshake.
- The accumulator clears on entry to IDLE.
- Asserting `rst_n` low mid-operation returns the block to IDLE within the same cycle. Weights already written are retained.

## Configuration
- `NEURON_SAT_EN` defined: accumulator and bias additions saturate to 0x7FFF…F / 0x800…0 on signed overflow.
- `NEURON_SAT_EN` undefined: both additions wrap modulo 2^(2DW). Output clamping applies in both builds.

## Structure
- `neuron_pkg` holds:
  - the `state_e` FSM enum
  - the `act_e` enum (LINEAR, RELU)
  - the `sat_add` function
  - the `BEATS` localparam helper
- Sub-module `neuron_wmem`: LANES-wide RAM with NUM_WEIGHT/LANES rows, one write port with lane enable, and a registered read port.

## Test plan
All scenarios use DW=16, LANES=2, NUM_WEIGHT=4, WEIGHT_INT_WIDTH=1.
- Weights 0x2000 ×4, bias 0x2000, inputs 0x4000 in 2 beats, act_sel=0 → `out` = 0x6000, `out_valid` at T+5.
- Weights 0xE000, bias 0, inputs 0x4000 → act_sel=0 gives 0xC000; act_sel=1 gives 0x0000.
- Weights and inputs 0x8000 → with `NEURON_SAT_EN` the result is 0x7FFF; without it the result is 0x0000.
- Hold `out_ready` low for 10 cycles → `out` stable, `in_ready` = 0, and a write with matching IDs is ignored. Then raise `out_ready` → `in_ready` = 1 on the next cycle.
- Weight writes with mismatched `config_neuron_num` → RAM unchanged and the result uses the previous weights. Five matching writes → the fifth wraps to row 0, lane 0.
- Pull `rst_n` low after beat 1 → `busy`, `out_valid` and the accumulator are 0 immediately. A fresh 2-beat run then gives the correct result.
